// File: rtl/math_block_pipe.sv
// -----------------------------------------------------------------------------
// math_block_pipe
//   Three-stage multiply-accumulate block with run-time lane splitting.
//   S1 captures the selected operand/coefficient and per-sample controls,
//   S2 forms the per-lane products and updates the lane accumulators,
//   S3 shifts/rounds/saturates each accumulator and packs the lane results.
//
//   Parameters
//     DATA_W  : operand/result width; must be a multiple of 8, at least 8
//     GUARD_W : accumulator guard bits above the full product width per lane
//     SHIFT_W : width of out_shift
//
//   Ports
//     EFPGA2MATHB_CLK          : clock, all flops on the rising edge
//     reset                    : asynchronous, active-high
//     clk_en                   : pipeline advance enable (low freezes all state)
//     TPRAM_/EFPGA_ *_OPER_*   : operand sources
//     TPRAM_/EFPGA_ *_COEF_*   : coefficient sources
//     oper_def / coef_def      : 0x = eFPGA, 10 = TPRAM, 11 = dynamic via *_sel
//     oper_sel / coef_sel      : dynamic select (1 = TPRAM)
//     in_valid                 : sample qualifier for data and controls
//     mode                     : lane split 1/2/4/8 lanes of DATA_W/N bits
//     tc                       : 1 = signed two's complement, 0 = unsigned
//     acc_clear/acc_rnd/acc_sat: accumulate controls, sampled with in_valid
//     out_shift                : right shift applied to each accumulator
//     mac_out                  : packed lane results, lane 0 in the LSBs
//     out_valid                : single-cycle pulse per accepted sample
//     sat_flag                 : per-lane saturation/overflow flag
// -----------------------------------------------------------------------------
module math_block_pipe #(
    parameter int DATA_W  = 32,
    parameter int GUARD_W = 8,
    parameter int SHIFT_W = 6
) (
    input  logic               EFPGA2MATHB_CLK,
    input  logic               reset,
    input  logic               clk_en,
    input  logic [DATA_W-1:0]  TPRAM_MATHB_OPER_R_DATA,
    input  logic [DATA_W-1:0]  EFPGA_MATHB_OPER_DATA,
    input  logic [DATA_W-1:0]  TPRAM_MATHB_COEF_R_DATA,
    input  logic [DATA_W-1:0]  EFPGA_MATHB_COEF_DATA,
    input  logic [1:0]         oper_def,
    input  logic [1:0]         coef_def,
    input  logic               oper_sel,
    input  logic               coef_sel,
    input  logic               in_valid,
    input  logic [1:0]         mode,
    input  logic               tc,
    input  logic               acc_clear,
    input  logic               acc_rnd,
    input  logic               acc_sat,
    input  logic [SHIFT_W-1:0] out_shift,
    output logic [DATA_W-1:0]  mac_out,
    output logic               out_valid,
    output logic [7:0]         sat_flag
);

    // Accumulators are sized for the widest lane (mode 00); narrower modes
    // use only the low 2*LW+GUARD_W bits and keep the rest at zero.
    localparam int ACC_MAX = 2 * DATA_W + GUARD_W;
    localparam int OPW     = DATA_W + 1;   // holds any LW-bit signed or unsigned value
    localparam int XW      = ACC_MAX + 2;  // headroom for sign and rounding carry

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic              flag;
    } lane_res_t;

    function automatic logic [DATA_W-1:0] pick_src(input logic [1:0] def, input logic sel,
                                                   input logic [DATA_W-1:0] tpram,
                                                   input logic [DATA_W-1:0] efpga);
        return (def[1] && (!def[0] || sel)) ? tpram : efpga;
    endfunction

    function automatic logic [ACC_MAX-1:0] acc_mask(input logic [1:0] m);
        return ~({ACC_MAX{1'b1}} << (2 * (DATA_W >> m) + GUARD_W));
    endfunction

    // Extracts lane 'lane' of d and extends it to OPW bits per tc.
    function automatic logic signed [OPW-1:0] lane_operand(input logic [DATA_W-1:0] d, input int lane,
                                                           input logic [1:0] m, input logic is_signed);
        int                lw;
        logic [DATA_W-1:0] msk;
        logic [DATA_W-1:0] v;
        logic              neg;
        lw  = DATA_W >> m;
        msk = ~({DATA_W{1'b1}} << lw);
        v   = (d >> (lane * lw)) & msk;
        neg = is_signed && |(v & (msk ^ (msk >> 1)));
        if (neg) v = v | ~msk;
        return $signed({neg, v});
    endfunction

    function automatic logic [ACC_MAX-1:0] lane_product(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                        input int lane, input logic [1:0] m,
                                                        input logic is_signed);
        logic signed [2*OPW-1:0] p;
        p = (2*OPW)'(lane_operand(a, lane, m, is_signed)) * (2*OPW)'(lane_operand(b, lane, m, is_signed));
        return ACC_MAX'(p) & acc_mask(m);
    endfunction

    // Output conditioning of one accumulator: optional rounding, shift, then
    // clamp or truncate to the lane width with an out-of-range flag.
    function automatic lane_res_t lane_result(input logic [ACC_MAX-1:0] acc, input logic [1:0] m,
                                              input logic is_signed, input logic rnd, input logic sat,
                                              input logic [SHIFT_W-1:0] sh);
        lane_res_t          res;
        int                 lw;
        int                 aw;
        logic [ACC_MAX-1:0] amsk;
        logic [DATA_W-1:0]  lmsk;
        logic signed [XW-1:0] x;
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        lw   = DATA_W >> m;
        aw   = 2 * lw + GUARD_W;
        amsk = acc_mask(m);
        lmsk = ~({DATA_W{1'b1}} << lw);
        x    = XW'(acc & amsk);
        if (is_signed && |(acc & amsk & ~(amsk >> 1))) x = x | ~XW'(amsk);
        if (int'(sh) >= aw) begin
            x = {XW{x[XW-1]}};
        end else begin
            if (rnd && sh != '0) x = x + (XW'(1) <<< (sh - SHIFT_W'(1)));
            x = x >>> sh;
        end
        if (is_signed) begin
            hi = (XW'(1) <<< (lw - 1)) - XW'(1);
            lo = -(XW'(1) <<< (lw - 1));
        end else begin
            hi = (XW'(1) <<< lw) - XW'(1);
            lo = '0;
        end
        res.flag = (x > hi) || (x < lo);
        if (sat && x > hi)      res.value = DATA_W'(hi) & lmsk;
        else if (sat && x < lo) res.value = DATA_W'(lo) & lmsk;
        else                    res.value = DATA_W'(x) & lmsk;
        return res;
    endfunction

    // ---------------- S1: capture ----------------
    logic [DATA_W-1:0]  oper1, coef1;
    logic [1:0]         mode1, last_mode;
    logic               v1, tc1, clear1, rnd1, sat1;
    logic [SHIFT_W-1:0] shift1;
    logic               idle_clear;

    assign idle_clear = clk_en && !in_valid && acc_clear;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge EFPGA2MATHB_CLK or posedge reset) begin
        if (reset) begin
            v1        <= 1'b0;
            oper1     <= '0;
            coef1     <= '0;
            mode1     <= '0;
            last_mode <= '0;
            tc1       <= 1'b0;
            clear1    <= 1'b0;
            rnd1      <= 1'b0;
            sat1      <= 1'b0;
            shift1    <= '0;
        end else if (clk_en) begin
            v1 <= in_valid;
            if (in_valid) begin
                oper1     <= pick_src(oper_def, oper_sel, TPRAM_MATHB_OPER_R_DATA, EFPGA_MATHB_OPER_DATA);
                coef1     <= pick_src(coef_def, coef_sel, TPRAM_MATHB_COEF_R_DATA, EFPGA_MATHB_COEF_DATA);
                mode1     <= mode;
                tc1       <= tc;
                // A lane-split change makes old accumulator contents meaningless.
                clear1    <= acc_clear || (mode != last_mode);
                rnd1      <= acc_rnd;
                sat1      <= acc_sat;
                shift1    <= out_shift;
                last_mode <= mode;
            end
        end
    end

    // ---------------- S2: control pipe ----------------
    logic               v2, tc2, rnd2, sat2;
    logic [1:0]         mode2;
    logic [SHIFT_W-1:0] shift2;

    always_ff @(posedge EFPGA2MATHB_CLK or posedge reset) begin
        if (reset) begin
            v2     <= 1'b0;
            mode2  <= '0;
            tc2    <= 1'b0;
            rnd2   <= 1'b0;
            sat2   <= 1'b0;
            shift2 <= '0;
        end else if (clk_en) begin
            v2 <= v1;
            if (v1) begin
                mode2  <= mode1;
                tc2    <= tc1;
                rnd2   <= rnd1;
                sat2   <= sat1;
                shift2 <= shift1;
            end
        end
    end

    // ---------------- S2 accumulators and S3 lane conditioning ----------------
    logic [DATA_W-1:0] word_chain [9];
    logic [7:0]        res_flag;

    assign word_chain[0] = '0;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        logic [ACC_MAX-1:0] acc_q, prod, acc_d;
        logic               lane_on1, lane_on2;
        lane_res_t          lane_res;
        logic [DATA_W-1:0]  lane_word;

        assign lane_on1 = (g < (1 << mode1));
        assign lane_on2 = (g < (1 << mode2));
        assign prod     = lane_product(oper1, coef1, g, mode1, tc1);
        assign acc_d    = lane_on1 ? (((clear1 ? '0 : acc_q) + prod) & acc_mask(mode1)) : '0;

        // NOTE: accumulators get an explicit reset: the first sample after
        // reset must accumulate from zero, so they cannot power up as don't-care.
        always_ff @(posedge EFPGA2MATHB_CLK or posedge reset) begin
            if (reset)           acc_q <= '0;
            else if (idle_clear) acc_q <= '0;  // clear command wins over an in-flight update
            else if (clk_en && v1) acc_q <= acc_d;
        end

        assign lane_res      = lane_result(acc_q, mode2, tc2, rnd2, sat2, shift2);
        assign lane_word     = lane_on2 ? (lane_res.value << (g * (DATA_W >> mode2))) : '0;
        assign word_chain[g+1] = word_chain[g] | lane_word;
        assign res_flag[g]   = lane_on2 && lane_res.flag;
    end

    // ---------------- S3: output register ----------------
    always_ff @(posedge EFPGA2MATHB_CLK or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            mac_out   <= '0;
            sat_flag  <= '0;
        end else if (clk_en) begin
            out_valid <= v2;
            if (v2) begin
                mac_out  <= word_chain[8];
                sat_flag <= res_flag;
            end
        end
    end

endmodule
